// File: rtl/ad_cail_mch_if.sv
// ad_cail_mch_if: sample, gain-write, calibration and corrected-output signals of ad_cail_mch
interface ad_cail_mch_if #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 18,
  parameter int CH_W   = 3
);
  logic                     cail_en;
  logic [3:0]               avg_shift;
  logic                     din_valid;
  logic [CH_W-1:0]          din_ch;
  logic signed [DATA_W-1:0] din;
  logic                     gain_we;
  logic [CH_W-1:0]          gain_ch;
  logic [GAIN_W-1:0]        gain_i;
  logic                     busy;
  logic                     cail_done;
  logic                     dout_valid;
  logic [CH_W-1:0]          dout_ch;
  logic signed [DATA_W-1:0] dout;
  modport master (
    output cail_en, avg_shift, din_valid, din_ch, din, gain_we, gain_ch, gain_i,
    input  busy, cail_done, dout_valid, dout_ch, dout
  );
  modport slave (
    input  cail_en, avg_shift, din_valid, din_ch, din, gain_we, gain_ch, gain_i,
    output busy, cail_done, dout_valid, dout_ch, dout
  );
endinterface

// File: rtl/ad_cail_mch.sv
// ad_cail_mch: multi-channel ADC offset calibration by averaging plus per-channel gain/offset correction
module ad_cail_mch #(
  parameter int CH_NUM = 8,
  parameter int DATA_W = 16,
  parameter int GAIN_W = 18,
  parameter int CH_W   = 3
) (
  input logic           clk,
  input logic           rst_n,
  ad_cail_mch_if.slave  bus
);
  localparam int ACC_W  = DATA_W + 8;
  localparam int SUB_W  = DATA_W + 1;
  localparam int PRD_W  = SUB_W + GAIN_W + 1;
  localparam int CH_CNT = 1 << CH_W;
  localparam logic signed [PRD_W-1:0] SAT_HI = (PRD_W'(1) <<< (DATA_W - 1)) - PRD_W'(1);
  localparam logic signed [PRD_W-1:0] SAT_LO = -SAT_HI - PRD_W'(1);
  typedef enum logic [1:0] {IDLE, ACC, STORE} state_t;
  state_t                   r_state, w_next;
  logic [3:0]               r_shift;
  logic signed [ACC_W-1:0]  r_acc [CH_CNT];
  logic [8:0]               r_cnt [CH_CNT];
  logic signed [DATA_W-1:0] r_off [CH_CNT];
  logic [GAIN_W-1:0]        r_gain [CH_CNT];
  logic                     r_s1_v;
  logic [CH_W-1:0]          r_s1_ch;
  logic signed [SUB_W-1:0]  r_s1_diff;
  logic [GAIN_W-1:0]        r_s1_gain;
  logic                     r_dv;
  logic [CH_W-1:0]          r_dch;
  logic signed [DATA_W-1:0] r_dout;
  logic [8:0]               w_target;
  logic                     w_all_full;
  logic                     w_acc_en;
  logic signed [PRD_W-1:0]  w_prod, w_scaled;
  logic signed [DATA_W-1:0] w_sat;
  assign w_target = 9'd1 << r_shift;
  always_comb begin
    w_all_full = 1'b1;
    for (int c = 0; c < CH_NUM; c++) w_all_full = w_all_full && (r_cnt[c] == w_target);
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (bus.cail_en ? ACC : IDLE) :
             (r_state == ACC)  ? (w_all_full ? STORE : ACC) : IDLE;
  end
  assign w_acc_en = (r_state == ACC) && bus.din_valid && (int'(bus.din_ch) < CH_NUM) &&
                    (r_cnt[bus.din_ch] != w_target);
  // Gain is unsigned Q2.16, so it gets a zero sign bit before the signed multiply
  assign w_prod   = PRD_W'(r_s1_diff) * PRD_W'($signed({1'b0, r_s1_gain}));
  assign w_scaled = w_prod >>> 16;
  assign w_sat    = (w_scaled > SAT_HI) ? {1'b0, {(DATA_W-1){1'b1}}} :
                    (w_scaled < SAT_LO) ? {1'b1, {(DATA_W-1){1'b0}}} : w_scaled[DATA_W-1:0];
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_s1_v    <= 1'b0;
      r_s1_ch   <= '0;
      r_s1_diff <= '0;
      r_s1_gain <= '0;
      r_dv      <= 1'b0;
      r_dch     <= '0;
      r_dout    <= '0;
      for (int c = 0; c < CH_CNT; c++) begin
        r_acc[c]  <= '0;
        r_cnt[c]  <= '0;
        r_off[c]  <= '0;
        r_gain[c] <= GAIN_W'(32'h10000);
      end
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.cail_en) begin
        r_shift <= (bus.avg_shift > 4'd8) ? 4'd8 : bus.avg_shift;
        for (int c = 0; c < CH_CNT; c++) begin
          r_acc[c] <= '0;
          r_cnt[c] <= '0;
        end
      end
      if (w_acc_en) begin
        r_acc[bus.din_ch] <= r_acc[bus.din_ch] + ACC_W'(bus.din);
        r_cnt[bus.din_ch] <= r_cnt[bus.din_ch] + 9'd1;
      end
      if (r_state == STORE)
        for (int c = 0; c < CH_NUM; c++) r_off[c] <= DATA_W'(r_acc[c] >>> r_shift);
      if (bus.gain_we && int'(bus.gain_ch) < CH_NUM) r_gain[bus.gain_ch] <= bus.gain_i;
      r_s1_v    <= bus.din_valid && (r_state == IDLE);
      r_s1_ch   <= bus.din_ch;
      r_s1_diff <= SUB_W'(bus.din) - SUB_W'(r_off[bus.din_ch]);
      r_s1_gain <= r_gain[bus.din_ch];
      r_dv      <= r_s1_v;
      if (r_s1_v) begin
        r_dch  <= r_s1_ch;
        r_dout <= w_sat;
      end
    end
  end
  assign bus.busy       = (r_state != IDLE);
  assign bus.cail_done  = (r_state == STORE);
  assign bus.dout_valid = r_dv;
  assign bus.dout_ch    = r_dch;
  assign bus.dout       = r_dout;
endmodule

// File: doc/ad_cail_mch.md
AD_CAIL_MCH -- requirements
Module: ad_cail_mch

Interface
REQ-001 SHALL have parameter CH_NUM, default 8, number of ADC channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, signed sample width.
REQ-003 SHALL have parameter GAIN_W, default 18, unsigned gain width, format Q2.16.
REQ-004 SHALL have parameter CH_W, default 3, channel index width (2^CH_W >= CH_NUM).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-high (1 = reset).
REQ-007 SHALL have port cail_en  input  1  one-cycle pulse that starts an offset calibration.
REQ-008 SHALL have port avg_shift  input  4  log2 of samples per channel to average; values >8 treated as 8.
REQ-009 SHALL have port din_valid  input  1  sample strobe.
REQ-010 SHALL have port din_ch  input  CH_W  channel of din.
REQ-011 SHALL have port din  input  DATA_W  signed raw sample.
REQ-012 SHALL have port gain_we  input  1  gain write strobe.
REQ-013 SHALL have port gain_ch  input  CH_W  channel of gain write.
REQ-014 SHALL have port gain_i  input  GAIN_W  gain value, Q2.16.
REQ-015 SHALL have port busy  output  1  high while calibration in progress.
REQ-016 SHALL have port cail_done  output  1  one-cycle pulse when new offsets are stored.
REQ-017 SHALL have port dout_valid  output  1  corrected-sample strobe.
REQ-018 SHALL have port dout_ch  output  CH_W  channel of dout.
REQ-019 SHALL have port dout  output  DATA_W  signed corrected sample.

Function
REQ-020 SHALL implement FSM states IDLE, ACC, STORE; IDLE->ACC on cail_en, ACC->STORE when every channel has 2^avg_shift samples, STORE->IDLE after one cycle.
REQ-021 SHALL latch avg_shift on the cail_en cycle; later changes have no effect until the next calibration.
REQ-022 SHALL ignore cail_en while busy=1.
REQ-023 SHALL clear all per-channel accumulators (DATA_W+8 bits, signed) and sample counters on entering ACC.
REQ-024 SHALL, in ACC, add each valid din to its channel accumulator; samples on a channel whose counter is full, or with din_ch >= CH_NUM, are discarded.
REQ-025 SHALL, in STORE, write offset[ch] = acc[ch] arithmetically shifted right by avg_shift (floor), truncated to DATA_W, and assert cail_done for that one cycle.
REQ-026 SHALL drive busy=1 in ACC and STORE, 0 in IDLE.
REQ-027 SHALL, in IDLE only, compute dout = sat((din - offset[din_ch]) * gain[din_ch] >>> 16) to DATA_W signed range; subtraction in DATA_W+1 bits, product full width, shift is floor.
REQ-028 SHALL have 2-cycle latency: dout_valid/dout_ch/dout registered 2 clocks after a din_valid accepted in IDLE; pipeline accepts one sample per clock.
REQ-029 SHALL suppress dout_valid for samples arriving in ACC or STORE; samples already in the pipeline on cail_en still complete.
REQ-030 SHALL read offset and gain in pipeline stage 1; a gain_we at cycle t affects samples with din_valid at t+1 onward, and new offsets affect samples from the cycle after cail_done.
REQ-031 SHALL accept gain_we in any state; writes with gain_ch >= CH_NUM are ignored.
REQ-032 SHALL saturate dout to +2^(DATA_W-1)-1 / -2^(DATA_W-1) on overflow.

Reset
REQ-033 SHALL, on rst_n=1 at a clock edge, set state IDLE, busy=0, cail_done=0, dout_valid=0, dout=0, dout_ch=0, all offsets 0, all gains 0x10000 (1.0), accumulators/counters 0, pipeline flushed.
REQ-034 SHALL abort calibration on reset mid-ACC with no cail_done and offsets 0.

Verification
REQ-035 SHALL test: after reset, din=100 ch0 -> dout=100, dout_ch=0, two cycles later.
REQ-036 SHALL test: cail_en, avg_shift=2, ch0 samples 10,11,12,13, other channels four 0s -> cail_done once, offset0=11; then din=111 ch0 -> dout=100.
REQ-037 SHALL test: gain ch1=0x20000; din=20000 -> 32767; din=-20000 -> -32768.
REQ-038 SHALL test: avg_shift=1, ch2 samples -3,-4 (others 0) -> offset2=-4; gain ch2=0x08000, din=-7 -> dout=-2.
REQ-039 SHALL test: second cail_en while busy ignored (single cail_done); rst_n mid-ACC -> busy=0 next cycle, ch0 din=5 -> dout=5.
REQ-040 SHALL test: back-to-back din_valid on alternating channels with gain_we on the same cycle -> one dout per input, in order, old gain for that cycle's sample.
